// File: rtl/rstseq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, reset-cause codes
// and a helper that sizes the watchdog timer terminal.
// Imported by reset_sequencer and rstseq_stage_timer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_RST  = 2'b00;
  localparam cause_t CAUSE_LOCK = 2'b01;
  localparam cause_t CAUSE_SW   = 2'b10;
  localparam cause_t CAUSE_WDOG = 2'b11;

  // Period handed to the shared timer so that its terminal flag marks the
  // cycle on which a width-bit watchdog would step onto all-ones.
  function automatic int wdog_period(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/rstseq_stage_timer.sv
// Free-running period timer: counts while enabled, wraps to zero after the
// terminal count, and flags the terminal cycle (count == DELAY-1).
// Ports:
//   CPU_CLK, RST   clock and synchronous active-low reset
//   i_clr          force count to zero (wins over i_en)
//   i_en           advance the count this cycle
//   o_term         high while count == DELAY-1
module rstseq_stage_timer
  import rstseq_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DELAY = 524288
) (
  input  logic CPU_CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(DELAY - 1);

  logic [WIDTH-1:0] r_cnt;

  assign o_term = (r_cnt == TERM);

  always_ff @(posedge CPU_CLK) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: waits for PLL lock, then releases CHANNELS
// active-low resets in ascending order, DELAY cycles apart. Re-sequences on
// lock loss, on sw_req while running, or on watchdog expiry, and reports why.
// Optional watchdog: define RSTSEQ_WATCHDOG_EN to build it.
// Ports:
//   CPU_CLK, RST   clock and synchronous active-low reset
//   lock           PLL lock level (already in the CPU_CLK domain)
//   sw_req         one-cycle pulse, re-sequence request (honoured in RUN only)
//   wdog_kick      one-cycle pulse, restarts the watchdog
//   rst_n_out      sequenced active-low resets, bit 0 released first
//   seq_done       high while every channel is released
//   cause          last reset cause: 00 RST, 01 lock, 10 software, 11 watchdog
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 20,
  parameter int DELAY      = 524288,
  parameter int WDOG_WIDTH = 24
) (
  input  logic                CPU_CLK,
  input  logic                RST,
  input  logic                lock,
  input  logic                sw_req,
  input  logic                wdog_kick,
  output logic [CHANNELS-1:0] rst_n_out,
  output logic                seq_done,
  output logic [1:0]          cause
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
    $error("reset_sequencer: CHANNELS must be in 1..16");
  end
  if ((DELAY < 2) || (longint'(DELAY) > ((longint'(1) << CNT_WIDTH) - 1))) begin : g_bad_delay
    $error("reset_sequencer: DELAY must satisfy 2 <= DELAY <= 2**CNT_WIDTH-1");
  end
  if (WDOG_WIDTH < 2) begin : g_bad_wdog
    $error("reset_sequencer: WDOG_WIDTH must be at least 2");
  end

  state_t             r_state;
  logic [CHANNELS-1:0] r_rst_n;
  logic               r_seq_done;
  cause_t             r_cause;
  logic [IDX_W-1:0]   r_idx;

  logic w_stage_en;
  logic w_stage_clr;
  logic w_stage_term;
  logic w_wdog_expire;

  // The stage timer only runs in STAGE; every other state holds it at zero,
  // so WAIT_LOCK always hands STAGE a fresh count.
  assign w_stage_en  = (r_state == STAGE);
  assign w_stage_clr = !w_stage_en;

  rstseq_stage_timer #(
    .WIDTH (CNT_WIDTH),
    .DELAY (DELAY)
  ) u_stage_timer (
    .CPU_CLK (CPU_CLK),
    .RST     (RST),
    .i_clr   (w_stage_clr),
    .i_en    (w_stage_en),
    .o_term  (w_stage_term)
  );

`ifdef RSTSEQ_WATCHDOG_EN
  logic w_wdog_run;
  logic w_wdog_clr;
  logic w_wdog_term;

  assign w_wdog_run = (r_state == RUN);
  assign w_wdog_clr = !w_wdog_run || wdog_kick;

  // Terminal sits one below all-ones: expiry fires on the edge the count
  // would reach all-ones. A kick on that same cycle suppresses it.
  rstseq_stage_timer #(
    .WIDTH (WDOG_WIDTH),
    .DELAY (wdog_period(WDOG_WIDTH))
  ) u_wdog_timer (
    .CPU_CLK (CPU_CLK),
    .RST     (RST),
    .i_clr   (w_wdog_clr),
    .i_en    (w_wdog_run),
    .o_term  (w_wdog_term)
  );

  assign w_wdog_expire = w_wdog_run && w_wdog_term && !wdog_kick;
`else
  logic w_unused_kick;
  assign w_unused_kick = wdog_kick;
  assign w_wdog_expire = 1'b0;
`endif

  always_ff @(posedge CPU_CLK) begin
    if (!RST) begin
      r_state    <= HOLD;
      r_rst_n    <= '0;
      r_seq_done <= 1'b0;
      r_cause    <= CAUSE_RST;
      r_idx      <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          r_state <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          r_rst_n    <= '0;
          r_seq_done <= 1'b0;
          r_idx      <= '0;
          if (lock) begin
            r_state <= STAGE;
          end
        end

        STAGE: begin
          if (!lock) begin
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
            r_cause    <= CAUSE_LOCK;
            r_state    <= WAIT_LOCK;
          end else if (w_stage_term) begin
            // Channels are released low-to-high, so releasing r_idx is the
            // same as shifting one more 1 in from the bottom.
            r_rst_n <= (r_rst_n << 1) | CHANNELS'(1);
            if (r_idx == LAST_IDX) begin
              r_seq_done <= 1'b1;
              r_state    <= RUN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        RUN: begin
          if (!lock) begin
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
            r_cause    <= CAUSE_LOCK;
            r_state    <= WAIT_LOCK;
          end else if (w_wdog_expire) begin
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
            r_cause    <= CAUSE_WDOG;
            r_state    <= WAIT_LOCK;
          end else if (sw_req) begin
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
            r_cause    <= CAUSE_SW;
            r_state    <= WAIT_LOCK;
          end
        end

        default: begin
          r_state <= HOLD;
        end
      endcase
    end
  end

  assign rst_n_out = r_rst_n;
  assign seq_done  = r_seq_done;
  assign cause     = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int CH  = 3;
  localparam int DLY = 4;
  localparam int CW  = 8;
  localparam int WW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_l     = 1'b0;
  logic          lock      = 1'b0;
  logic          sw_req    = 1'b0;
  logic          wdog_kick = 1'b0;
  logic [CH-1:0] rst_n_out;
  logic          seq_done;
  logic [1:0]    cause;

  reset_sequencer #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW),
    .DELAY      (DLY),
    .WDOG_WIDTH (WW)
  ) dut (
    .CPU_CLK   (clk),
    .RST       (rst_l),
    .lock      (lock),
    .sw_req    (sw_req),
    .wdog_kick (wdog_kick),
    .rst_n_out (rst_n_out),
    .seq_done  (seq_done),
    .cause     (cause)
  );

  typedef struct {
    int            due;
    logic [CH-1:0] rst_n;
    logic          done;
    logic [1:0]    cause;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase plus elapsed cycles since lock was seen; the
  // number of released channels is simply elapsed / DLY.
  typedef enum {M_HOLD, M_WAIT, M_SEQ, M_RUN} mmode_t;
  mmode_t     m_mode  = M_HOLD;
  int         m_t     = 0;
  int         m_wd    = 0;
  logic [1:0] m_cause = 2'b00;

  task automatic model_step(input logic r, input logic l, input logic s, input logic k);
    logic wd_fire;
    wd_fire = 1'b0;
    if (!r) begin
      m_mode  = M_HOLD;
      m_cause = 2'b00;
    end else begin
      case (m_mode)
        M_HOLD: m_mode = M_WAIT;
        M_WAIT: if (l) begin m_mode = M_SEQ; m_t = 0; end
        M_SEQ: begin
          if (!l) begin
            m_mode = M_WAIT; m_cause = 2'b01;
          end else begin
            m_t = m_t + 1;
            if (m_t >= CH * DLY) begin m_mode = M_RUN; m_wd = 0; end
          end
        end
        M_RUN: begin
`ifdef RSTSEQ_WATCHDOG_EN
          wd_fire = !k && (m_wd + 1 == (1 << WW) - 1);
`endif
          if (!l)          begin m_mode = M_WAIT; m_cause = 2'b01; end
          else if (wd_fire) begin m_mode = M_WAIT; m_cause = 2'b11; end
          else if (s)       begin m_mode = M_WAIT; m_cause = 2'b10; end
          else m_wd = k ? 0 : m_wd + 1;
        end
        default: m_mode = M_HOLD;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic s, input logic k);
    exp_t e;
    @(posedge clk);
    #2;
    rst_l = r; lock = l; sw_req = s; wdog_kick = k;
    model_step(r, l, s, k);
    e.due   = cyc + 1;
    e.cause = m_cause;
    case (m_mode)
      M_SEQ:   begin e.rst_n = CH'((1 << (m_t / DLY)) - 1); e.done = 1'b0; end
      M_RUN:   begin e.rst_n = {CH{1'b1}};                   e.done = 1'b1; end
      default: begin e.rst_n = '0;                           e.done = 1'b0; end
    endcase
    sb.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors = vectors + 1;
      if (rst_n_out !== e.rst_n || seq_done !== e.done || cause !== e.cause) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs cyc %0d: rst_n_out/seq_done/cause got %b/%b/%b expected %b/%b/%b",
                 cyc, rst_n_out, seq_done, cause, e.rst_n, e.done, e.cause);
      end
    end
  end

  initial begin
    // Reset, then a full sequence with lock high.
    repeat (3) cycle(0, 0, 0, 0);
    repeat (16) cycle(1, 1, 0, 0);
    // Software request in RUN, then re-sequence.
    cycle(1, 1, 1, 0);
    repeat (18) cycle(1, 1, 0, 0);
    // Lock loss from RUN, then a one-cycle drop around the 011 point.
    cycle(1, 0, 0, 0);
    repeat (9) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (16) cycle(1, 1, 0, 0);
    // sw_req during STAGE is ignored.
    cycle(1, 0, 0, 0);
    repeat (5) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    repeat (10) cycle(1, 1, 0, 0);
    // sw_req and lock loss together in RUN: lock loss wins.
    cycle(1, 0, 1, 0);
    repeat (16) cycle(1, 1, 0, 0);
    // RST for one cycle in the middle of STAGE.
    cycle(1, 1, 1, 0);
    repeat (6) cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (18) cycle(1, 1, 0, 0);
    // Regular kicks, then none.
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, (i % 10) == 0);
    repeat (24) cycle(1, 1, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(199, 0) != 0,
            $urandom_range(39, 0) != 0,
            $urandom_range(19, 0) == 0,
            $urandom_range(7, 0) == 0);
    end
    repeat (3) @(negedge clk);
    vectors = vectors + 1;
    if (sb.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
